// File: rtl/pmp_cfg_loader.sv
// PMP entry loader: validates lock state against a pmpcfg shadow, then writes pmpaddr and pmpcfg.
// Define PMP_LOADER_LOCK_CHECK_EN to enable the lock checks.
module pmp_cfg_loader (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_idx,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_cfg,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        wr_en,
    output logic [31:0] rw_addr,
    output logic [31:0] wdata
);
    typedef enum logic [2:0] {IDLE, CHECK, WADDR, WCFG, RESP} state_t;

    state_t       r_state;
    logic [3:0]   r_idx;
    logic [31:0]  r_addr;
    logic [7:0]   r_cfg;
    logic [127:0] r_shadow;
    logic         r_ready;
    logic         r_rsp_valid;
    logic         r_wr_en;
    logic [31:0]  r_rw_addr;
    logic [31:0]  r_wdata;

    logic [7:0]   w_cfg_clean;
    logic [31:0]  w_merged;
    logic         w_lock;

    // Bits 6:5 of a pmpcfg byte are reserved and always stored as zero.
    assign w_cfg_clean = {r_cfg[7], 2'b00, r_cfg[4:0]};

    always_comb begin
        w_merged = r_shadow[{r_idx[3:2], 5'b00000} +: 32];
        w_merged[{r_idx[1:0], 3'b000} +: 8] = w_cfg_clean;
    end

`ifdef PMP_LOADER_LOCK_CHECK_EN
    logic [3:0] w_nidx;
    logic [7:0] w_cur_cfg;
    logic [7:0] w_nxt_cfg;
    logic       r_err;

    assign w_nidx    = r_idx + 4'd1;
    assign w_cur_cfg = r_shadow[{r_idx, 3'b000} +: 8];
    assign w_nxt_cfg = r_shadow[{w_nidx, 3'b000} +: 8];
    // A locked TOR entry above also freezes this entry's address; entry 15 has no neighbour.
    assign w_lock    = w_cur_cfg[7] |
                       ((r_idx != 4'd15) & w_nxt_cfg[7] & (w_nxt_cfg[4:3] == 2'b01));
    assign rsp_err   = r_err;
`else
    assign w_lock    = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign wr_en     = r_wr_en;
    assign rw_addr   = r_rw_addr;
    assign wdata     = r_wdata;

    always_ff @(posedge clock) begin
        if (r_state == IDLE && req_valid) begin
            r_idx  <= req_idx;
            r_addr <= req_addr;
            r_cfg  <= req_cfg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rw_addr   <= 32'd0;
            r_wdata     <= 32'd0;
            r_shadow    <= 128'd0;
`ifdef PMP_LOADER_LOCK_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_state <= CHECK;
                        r_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (w_lock) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
`ifdef PMP_LOADER_LOCK_CHECK_EN
                        r_err       <= 1'b1;
`endif
                    end else begin
                        r_state   <= WADDR;
                        r_wr_en   <= 1'b1;
                        r_rw_addr <= 32'h3B0 + {28'd0, r_idx};
                        r_wdata   <= r_addr;
                    end
                end
                WADDR: begin
                    r_state   <= WCFG;
                    r_wr_en   <= 1'b1;
                    r_rw_addr <= 32'h3A0 + {30'd0, r_idx[3:2]};
                    r_wdata   <= w_merged;
                end
                WCFG: begin
                    r_state     <= RESP;
                    r_wr_en     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_shadow[{r_idx, 3'b000} +: 8] <= w_cfg_clean;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
`ifdef PMP_LOADER_LOCK_CHECK_EN
                    r_err       <= 1'b0;
`endif
                end
                default: begin
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_wr_en     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_cfg_loader.sv
// Bench for pmp_cfg_loader: directed and random entry programming against a byte-level pmpcfg model.
module tb_pmp_cfg_loader;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_idx;
    logic [31:0] req_addr;
    logic [7:0]  req_cfg;
    logic        rsp_valid;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] rw_addr;
    logic [31:0] wdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  sh [16];
    logic [31:0] last_wd1;
    logic        last_err;

    pmp_cfg_loader dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_addr(req_addr), .req_cfg(req_cfg),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .wr_en(wr_en), .rw_addr(rw_addr), .wdata(wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_err(input int idx);
`ifdef PMP_LOADER_LOCK_CHECK_EN
        if (sh[idx][7]) return 1'b1;
        if (idx < 15 && sh[idx+1][7] && sh[idx+1][4:3] == 2'd1) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {sh[w*4+3], sh[w*4+2], sh[w*4+1], sh[w*4]};
    endfunction

    task automatic clean_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) sh[i] = 8'd0;
    endtask

    // Issue one request and check the whole transaction against the model.
    task automatic do_txn(input logic [3:0] idx, input logic [31:0] addr,
                          input logic [7:0] cfg, input bit hold);
        logic        e_err;
        logic [31:0] e_word;
        logic [31:0] wa [2];
        logic [31:0] wd [2];
        int          nwr, cyc, rdy_bad, w;
        bit          done;
        logic        got_err;

        w = 0;
        while (!req_ready && w < 20) begin @(negedge clock); w++; end
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_idx = idx; req_addr = addr; req_cfg = cfg;
        @(posedge clock); #1;
        if (hold) begin req_idx = ~idx; req_addr = ~addr; req_cfg = ~cfg; end
        else req_valid = 1'b0;

        e_err = model_err(int'(idx));
        if (!e_err) sh[idx] = cfg & 8'h9F;
        e_word = model_word(int'(idx) / 4);

        nwr = 0; cyc = 0; rdy_bad = 0; done = 0; got_err = 1'b0;
        wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clock);
            if (hold && k == 3) req_valid = 1'b0;
            if (req_ready !== 1'b0) rdy_bad++;
            if (wr_en === 1'b1) begin
                if (nwr < 2) begin wa[nwr] = rw_addr; wd[nwr] = wdata; end
                nwr++;
            end
            if (rsp_valid === 1'b1) begin done = 1; cyc = k; got_err = rsp_err; end
        end

        n_chk++;
        if (!done) begin n_fail++; $display("FAIL rsp_timeout idx=%0d: no rsp_valid within 12 cycles", idx); end
        n_chk++;
        if (cyc != (e_err ? 2 : 4)) begin
            n_fail++; $display("FAIL rsp_latency idx=%0d: cycle %0d required %0d", idx, cyc, e_err ? 2 : 4);
        end
        n_chk++;
        if (got_err !== e_err) begin
            n_fail++; $display("FAIL rsp_err idx=%0d: got %b required %b", idx, got_err, e_err);
        end
        n_chk++;
        if (nwr != (e_err ? 0 : 2)) begin
            n_fail++; $display("FAIL wr_count idx=%0d: got %0d required %0d", idx, nwr, e_err ? 0 : 2);
        end
        n_chk++;
        if (rdy_bad != 0) begin
            n_fail++; $display("FAIL ready_busy idx=%0d: req_ready high in %0d busy cycles, required 0", idx, rdy_bad);
        end
        if (!e_err && nwr == 2) begin
            n_chk++;
            if (wa[0] !== 32'h3B0 + idx || wd[0] !== addr) begin
                n_fail++; $display("FAIL addr_write idx=%0d: %h<=%h required %h<=%h", idx, wa[0], wd[0], 32'h3B0 + idx, addr);
            end
            n_chk++;
            if (wa[1] !== 32'h3A0 + idx / 4 || wd[1] !== e_word) begin
                n_fail++; $display("FAIL cfg_write idx=%0d: %h<=%h required %h<=%h", idx, wa[1], wd[1], 32'h3A0 + idx / 4, e_word);
            end
        end
        last_wd1 = wd[1];
        last_err = got_err;

        @(negedge clock);
        n_chk++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL after_rsp idx=%0d: rsp_valid=%b req_ready=%b wr_en=%b required 0 1 0", idx, rsp_valid, req_ready, wr_en);
        end
        if (!e_err && nwr == 2) begin
            n_chk++;
            if (rw_addr !== wa[1] || wdata !== wd[1]) begin
                n_fail++; $display("FAIL bus_hold idx=%0d: %h/%h required %h/%h", idx, rw_addr, wdata, wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_reset();
        clean_reset();
        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || wr_en !== 1'b0 ||
            rw_addr !== 32'd0 || wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rv=%b err=%b we=%b a=%h d=%h required 1 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, wr_en, rw_addr, wdata);
        end
    endtask

    task automatic test_basic();
        do_txn(4'd0, 32'h12345678, 8'h08, 0);
        n_chk++;
        if (last_wd1 !== 32'h00000008 || last_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_tor: wdata=%h err=%b required 00000008 0", last_wd1, last_err);
        end
    endtask

    task automatic test_lock();
        do_txn(4'd1, 32'h00001000, 8'h82, 0);
        n_chk++;
        if (last_wd1 !== 32'h00008208) begin
            n_fail++; $display("FAIL lock_write: wdata=%h required 00008208", last_wd1);
        end
        do_txn(4'd1, 32'h00002000, 8'h01, 0);
        n_chk++;
`ifdef PMP_LOADER_LOCK_CHECK_EN
        if (last_err !== 1'b1) begin
            n_fail++; $display("FAIL lock_refuse: err=%b required 1", last_err);
        end
`else
        if (last_err !== 1'b0 || last_wd1 !== 32'h00000108) begin
            n_fail++; $display("FAIL lock_disabled: err=%b wdata=%h required 0 00000108", last_err, last_wd1);
        end
`endif
    endtask

    task automatic test_tor_wrap();
        do_txn(4'd3, 32'h40000000, 8'h88, 0);
        do_txn(4'd2, 32'h30000000, 8'h01, 0);
        n_chk++;
`ifdef PMP_LOADER_LOCK_CHECK_EN
        if (last_err !== 1'b1) begin
            n_fail++; $display("FAIL tor_lock: err=%b required 1", last_err);
        end
`else
        if (last_err !== 1'b0) begin
            n_fail++; $display("FAIL tor_nolock: err=%b required 0", last_err);
        end
`endif
        do_txn(4'd15, 32'hF0000000, 8'h07, 0);
        n_chk++;
        if (last_wd1 !== 32'h07000000 || last_err !== 1'b0) begin
            n_fail++; $display("FAIL idx15_wrap: wdata=%h err=%b required 07000000 0", last_wd1, last_err);
        end
    endtask

    task automatic test_reserved_mask();
        do_txn(4'd5, 32'h00005000, 8'hE7, 0);
        n_chk++;
        if (last_wd1[15:8] !== 8'h87) begin
            n_fail++; $display("FAIL cfg_mask: byte1=%h required 87", last_wd1[15:8]);
        end
    endtask

    task automatic test_back_to_back();
        do_txn(4'd8, 32'h0000AAAA, 8'h19, 1);
        do_txn(4'd9, 32'h0000BBBB, 8'h0B, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            do_txn(4'($urandom_range(0, 15)), $urandom, 8'($urandom), ($urandom_range(0, 7) == 0));
    endtask

    task automatic test_reset_midflight();
        int seen;
        clean_reset();
        do_txn(4'd0, 32'h00000100, 8'h9D, 0);
        @(negedge clock);
        req_valid = 1'b1; req_idx = 4'd4; req_addr = 32'hCAFE0000; req_cfg = 8'h1F;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_chk++;
        if (wr_en !== 1'b1 || rw_addr !== 32'h3B4) begin
            n_fail++; $display("FAIL mid_waddr: wr_en=%b rw_addr=%h required 1 000003b4", wr_en, rw_addr);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (wr_en !== 1'b0 || rsp_valid !== 1'b0 || rw_addr !== 32'd0 || wdata !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset: we=%b rv=%b a=%h d=%h required 0 0 0 0", wr_en, rsp_valid, rw_addr, wdata);
        end
        for (int i = 0; i < 16; i++) sh[i] = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || wr_en !== 1'b0) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++; $display("FAIL abandoned: activity in %0d cycles after reset, required 0", seen);
        end
        do_txn(4'd0, 32'h00000200, 8'h01, 0);
        n_chk++;
        if (last_err !== 1'b0 || last_wd1 !== 32'h00000001) begin
            n_fail++; $display("FAIL post_reset: err=%b wdata=%h required 0 00000001", last_err, last_wd1);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_idx = 4'd0; req_addr = 32'd0; req_cfg = 8'd0;
        last_wd1 = 32'd0; last_err = 1'b0;
        for (int i = 0; i < 16; i++) sh[i] = 8'd0;
        test_reset();
        test_basic();
        test_lock();
        test_tor_wrap();
        test_reserved_mask();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
